// File: rtl/riscv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// riscv_ctrl_pkg
// Shared definitions for the multicycle RV32I control unit:
//   - RV32I opcode and funct3 constants for the supported subset
//   - immediate-format, ALU-operation and datapath mux-select encodings
//   - control FSM state enum
//   - moore_outputs(): per-state values of the registered datapath controls
//   - decode_imm(): immediate format selected while an instruction is decoded
// -----------------------------------------------------------------------------
package riscv_ctrl_pkg;

    // Opcodes (inst[6:0]) of the supported subset
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // Branch conditions (inst[14:12]) that are implemented
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    // Immediate generator format select
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_U = 2'b11;

    // ALU operation
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OP_LUI   = 2'b11;

    // ALU A operand select
    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    // Result mux select
    localparam logic [1:0] RES_ALU_OUT = 2'b00;
    localparam logic [1:0] RES_MEM     = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    // Memory address select
    localparam logic ADR_PC      = 1'b0;
    localparam logic ADR_ALU_OUT = 1'b1;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXECR  = 4'd7,
        S_EXECI  = 4'd8,
        S_ALUWB  = 4'd9,
        S_BRANCH = 4'd10,
        S_LUI    = 4'd11,
        S_TRAP   = 4'd12
    } ctrl_state_e;

    // Datapath controls that depend only on the state, so they can be
    // registered from the next-state value.
    typedef struct packed {
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
        logic       adr_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
    } moore_out_t;

    function automatic moore_out_t moore_outputs(input ctrl_state_e st);
        moore_out_t o;
        o = '0;
        case (st)
            S_FETCH: begin
                o.mem_read   = 1'b1;
                o.adr_src    = ADR_PC;
                o.alu_src_a  = SRC_A_PC;
                o.alu_src_b  = SRC_B_FOUR;
                o.alu_op     = ALU_OP_ADD;
                o.result_src = RES_ALU;
            end
            S_DECODE: begin
                // Branch target PC+imm is computed speculatively into ALUOut
                o.alu_src_a = SRC_A_OLD_PC;
                o.alu_src_b = SRC_B_IMM;
                o.alu_op    = ALU_OP_ADD;
            end
            S_MEMADR: begin
                o.alu_src_a = SRC_A_RS1;
                o.alu_src_b = SRC_B_IMM;
                o.alu_op    = ALU_OP_ADD;
            end
            S_MEMRD: begin
                o.mem_read = 1'b1;
                o.adr_src  = ADR_ALU_OUT;
            end
            S_MEMWB: begin
                o.result_src = RES_MEM;
                o.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                o.mem_write = 1'b1;
                o.adr_src   = ADR_ALU_OUT;
            end
            S_EXECR: begin
                o.alu_src_a = SRC_A_RS1;
                o.alu_src_b = SRC_B_RS2;
                o.alu_op    = ALU_OP_FUNCT;
            end
            S_EXECI: begin
                o.alu_src_a = SRC_A_RS1;
                o.alu_src_b = SRC_B_IMM;
                o.alu_op    = ALU_OP_FUNCT;
            end
            S_ALUWB: begin
                o.result_src = RES_ALU_OUT;
                o.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                o.alu_src_a  = SRC_A_RS1;
                o.alu_src_b  = SRC_B_RS2;
                o.alu_op     = ALU_OP_SUB;
                o.result_src = RES_ALU_OUT;
            end
            S_LUI: begin
                o.alu_src_b = SRC_B_IMM;
                o.alu_op    = ALU_OP_LUI;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    function automatic logic [1:0] decode_imm(input logic [6:0] op);
        logic [1:0] fmt;
        case (op)
            OP_STORE:  fmt = IMM_S;
            OP_BRANCH: fmt = IMM_B;
            OP_LUI:    fmt = IMM_U;
            default:   fmt = IMM_I;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// -----------------------------------------------------------------------------
// mem_wait_timer
// Counts cycles spent waiting for mem_ready in a memory-access state and flags
// a timeout in the WAIT_LIMIT-th consecutive cycle without mem_ready.
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   clear       zero the counter (asserted by the FSM on every state change)
//   waiting     FSM is in a state that waits for memory
//   mem_ready   memory completed this cycle
//   timeout     limit cycle reached with mem_ready still low
// -----------------------------------------------------------------------------
module mem_wait_timer #(
    parameter int WAIT_LIMIT = 255,
    parameter int CNT_W      = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic waiting,
    input  logic mem_ready,
    output logic timeout
);

    // Counter holds the number of already-expired wait cycles, so the
    // WAIT_LIMIT-th waiting cycle sees WAIT_LIMIT-1.
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(WAIT_LIMIT - 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (waiting && !mem_ready) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // A ready in the limit cycle masks the timeout.
    assign timeout = waiting && !mem_ready && (count_reg == LAST_WAIT);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_fsm
// Main control FSM of the multicycle RV32I core: fetch, decode, execute,
// memory and writeback for loads, stores, R-type, I-ALU, beq/bne and lui.
// Ports:
//   clk, rst_n         clock / asynchronous active-low reset
//   opcode, funct3     fields of the instruction register
//   zero               ALU zero flag (branch condition)
//   mem_ready          memory finished the current access this cycle
//   imm_ctrl           immediate format (I/S/B/U)
//   alu_src_a/b        ALU operand selects
//   alu_op             ALU operation class
//   result_src         result mux select
//   adr_src            memory address select (PC / ALUOut)
//   mem_read/write     memory strobes
//   ir_write, pc_write instruction register / PC load enables
//   reg_write          register file write enable
//   illegal, bus_err   sticky error flags, cleared only by reset
// -----------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
    parameter int WAIT_LIMIT = 255,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [1:0] imm_ctrl,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       adr_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       illegal,
    output logic       bus_err
);

    import riscv_ctrl_pkg::*;

    ctrl_state_e state_reg;
    ctrl_state_e state_next;
    moore_out_t  out_reg;
    logic        illegal_reg;
    logic        bus_err_reg;
    logic        timeout;
    logic        waiting;
    logic        timer_clear;
    logic        branch_taken;

    assign waiting     = (state_reg == S_FETCH) || (state_reg == S_MEMRD) ||
                         (state_reg == S_MEMWR);
    // Clearing on every state change guarantees a fresh count on entry to
    // any waiting state, including the MEMWR -> FETCH back-to-back case.
    assign timer_clear = (state_next != state_reg);

    mem_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT),
        .CNT_W      (CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (timer_clear),
        .waiting   (waiting),
        .mem_ready (mem_ready),
        .timeout   (timeout)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   state_next = S_FETCH;
            S_FETCH: begin
                if (mem_ready)    state_next = S_DECODE;
                else if (timeout) state_next = S_TRAP;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_IALU:           state_next = S_EXECI;
                    OP_LUI:            state_next = S_LUI;
                    OP_BRANCH: begin
                        if (funct3 == F3_BEQ || funct3 == F3_BNE) state_next = S_BRANCH;
                        else                                      state_next = S_TRAP;
                    end
                    default:           state_next = S_TRAP;
                endcase
            end
            S_MEMADR: state_next = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready)    state_next = S_MEMWB;
                else if (timeout) state_next = S_TRAP;
            end
            S_MEMWB:  state_next = S_FETCH;
            S_MEMWR: begin
                if (mem_ready)    state_next = S_FETCH;
                else if (timeout) state_next = S_TRAP;
            end
            S_EXECR:  state_next = S_ALUWB;
            S_EXECI:  state_next = S_ALUWB;
            S_ALUWB:  state_next = S_FETCH;
            S_BRANCH: state_next = S_FETCH;
            S_LUI:    state_next = S_ALUWB;
            S_TRAP:   state_next = S_TRAP;
            default:  state_next = S_TRAP;
        endcase
    end

    // State and all state-only controls are registered together, so the
    // strobes come straight from flops and drop the moment rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            out_reg     <= '0;
            illegal_reg <= 1'b0;
            bus_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            out_reg   <= moore_outputs(state_next);
            if (state_reg == S_DECODE && state_next == S_TRAP)
                illegal_reg <= 1'b1;
            if (timeout)
                bus_err_reg <= 1'b1;
        end
    end

    // imm_ctrl follows the instruction register, which only changes in FETCH,
    // so it is stable for the whole of every later state.
    always_comb begin
        imm_ctrl = IMM_I;
        case (state_reg)
            S_DECODE: imm_ctrl = decode_imm(opcode);
            S_MEMADR: imm_ctrl = (opcode == OP_STORE) ? IMM_S : IMM_I;
            S_LUI:    imm_ctrl = IMM_U;
            default:  imm_ctrl = IMM_I;
        endcase
    end

    assign branch_taken = ((funct3 == F3_BEQ) && zero) ||
                          ((funct3 == F3_BNE) && !zero);

    // These loads must qualify on same-cycle handshakes (mem_ready, zero),
    // so they are decoded from the state register rather than registered.
    assign ir_write = (state_reg == S_FETCH) && mem_ready;
    assign pc_write = ir_write || ((state_reg == S_BRANCH) && branch_taken);

    assign alu_src_a  = out_reg.alu_src_a;
    assign alu_src_b  = out_reg.alu_src_b;
    assign alu_op     = out_reg.alu_op;
    assign result_src = out_reg.result_src;
    assign adr_src    = out_reg.adr_src;
    assign mem_read   = out_reg.mem_read;
    assign mem_write  = out_reg.mem_write;
    assign reg_write  = out_reg.reg_write;
    assign illegal    = illegal_reg;
    assign bus_err    = bus_err_reg;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl_fsm
// Drives instruction sequences into the control FSM and compares every cycle
// of outputs against an instruction-level reference model. The model expands
// each instruction into its list of expected cycles (fetch wait cycles, decode,
// execute/memory phases, traps) straight from the control table.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl_fsm;

    localparam int WL = 4;

    localparam int K_LOAD   = 0;
    localparam int K_STORE  = 1;
    localparam int K_RTYPE  = 2;
    localparam int K_IALU   = 3;
    localparam int K_BRANCH = 4;
    localparam int K_LUI    = 5;
    localparam int K_BAD    = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [1:0] imm_ctrl, alu_src_a, alu_src_b, alu_op, result_src;
    logic       adr_src, mem_read, mem_write, ir_write, pc_write, reg_write;
    logic       illegal, bus_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(
        .WAIT_LIMIT (WL),
        .CNT_W      (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct3     (funct3),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .imm_ctrl   (imm_ctrl),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .result_src (result_src),
        .adr_src    (adr_src),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .illegal    (illegal),
        .bus_err    (bus_err)
    );

    logic [17:0] obs;
    assign obs = {imm_ctrl, alu_src_a, alu_src_b, alu_op, result_src,
                  adr_src, mem_read, mem_write, ir_write, pc_write, reg_write,
                  illegal, bus_err};

    // One expected cycle: inputs to apply and the outputs required.
    typedef struct packed {
        logic        mr;
        logic        z;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [17:0] exp;
        logic [63:0] tag;
    } step_t;

    step_t plan[$];
    logic  m_ill = 1'b0;
    logic  m_be  = 1'b0;
    logic [6:0] bad_ops [7] = '{7'b1101111, 7'b1100111, 7'b0010111, 7'b1110011,
                                7'b0001111, 7'b0000000, 7'b1111111};

    function automatic logic [17:0] ov(input logic [1:0] imm, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] aop,
                                       input logic [1:0] rs, input logic adr,
                                       input logic mrd, input logic mwr,
                                       input logic irw, input logic pcw,
                                       input logic rw);
        return {imm, a, b, aop, rs, adr, mrd, mwr, irw, pcw, rw, m_ill, m_be};
    endfunction

    task automatic push(input logic mr, input logic z, input logic [6:0] op,
                        input logic [2:0] f3, input logic [17:0] e,
                        input logic [63:0] tag);
        step_t s;
        s.mr = mr; s.z = z; s.op = op; s.f3 = f3; s.exp = e; s.tag = tag;
        plan.push_back(s);
    endtask

    task automatic gen_trap();
        for (int i = 0; i < 3; i++)
            push(1'($urandom), 1'($urandom), 7'($urandom), 3'($urandom),
                 ov(2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "TRAP");
    endtask

    // Memory phase: mdly cycles without ready, then the ready cycle; a wait
    // that reaches WL cycles ends in TRAP with bus_err.
    task automatic gen_mem(input logic [6:0] op, input logic [2:0] f3,
                           input logic is_wr, input int mdly, output bit trapped);
        trapped = 1'b0;
        for (int i = 0; i < mdly && i < WL; i++)
            push(1'b0, 1'($urandom), op, f3,
                 ov(2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                    1'b1, !is_wr, is_wr, 1'b0, 1'b0, 1'b0),
                 is_wr ? "MEMWR" : "MEMRD");
        if (mdly >= WL) begin
            m_be = 1'b1;
            gen_trap();
            trapped = 1'b1;
            return;
        end
        push(1'b1, 1'($urandom), op, f3,
             ov(2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                1'b1, !is_wr, is_wr, 1'b0, 1'b0, 1'b0),
             is_wr ? "MEMWR" : "MEMRD");
    endtask

    task automatic gen_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic z, input int fdly, input int mdly,
                             output bit trapped);
        int         kind;
        logic [1:0] dimm;
        trapped = 1'b0;
        // Fetch: the instruction register still holds stale bits here.
        for (int i = 0; i < fdly && i < WL; i++)
            push(1'b0, 1'($urandom), 7'($urandom), 3'($urandom),
                 ov(2'b00, 2'b00, 2'b10, 2'b00, 2'b10,
                    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "FETCH");
        if (fdly >= WL) begin
            m_be = 1'b1;
            gen_trap();
            trapped = 1'b1;
            return;
        end
        push(1'b1, 1'($urandom), 7'($urandom), 3'($urandom),
             ov(2'b00, 2'b00, 2'b10, 2'b00, 2'b10,
                1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0), "FETCH_RDY");

        case (op)
            7'b0000011: begin kind = K_LOAD;   dimm = 2'b00; end
            7'b0100011: begin kind = K_STORE;  dimm = 2'b01; end
            7'b0110011: begin kind = K_RTYPE;  dimm = 2'b00; end
            7'b0010011: begin kind = K_IALU;   dimm = 2'b00; end
            7'b1100011: begin kind = K_BRANCH; dimm = 2'b10; end
            7'b0110111: begin kind = K_LUI;    dimm = 2'b11; end
            default:    begin kind = K_BAD;    dimm = 2'b00; end
        endcase
        push(1'($urandom), 1'($urandom), op, f3,
             ov(dimm, 2'b01, 2'b01, 2'b00, 2'b00,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "DECODE");

        case (kind)
            K_LOAD, K_STORE: begin
                push(1'($urandom), 1'($urandom), op, f3,
                     ov((kind == K_STORE) ? 2'b01 : 2'b00, 2'b10, 2'b01, 2'b00, 2'b00,
                        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "MEMADR");
                gen_mem(op, f3, kind == K_STORE, mdly, trapped);
                if (!trapped && kind == K_LOAD)
                    push(1'($urandom), 1'($urandom), op, f3,
                         ov(2'b00, 2'b00, 2'b00, 2'b00, 2'b01,
                            1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), "MEMWB");
            end
            K_RTYPE, K_IALU, K_LUI: begin
                if (kind == K_LUI)
                    push(1'($urandom), 1'($urandom), op, f3,
                         ov(2'b11, 2'b00, 2'b01, 2'b11, 2'b00,
                            1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "LUI");
                else
                    push(1'($urandom), 1'($urandom), op, f3,
                         ov(2'b00, 2'b10, (kind == K_IALU) ? 2'b01 : 2'b00, 2'b10, 2'b00,
                            1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
                         (kind == K_IALU) ? "EXECI" : "EXECR");
                push(1'($urandom), 1'($urandom), op, f3,
                     ov(2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), "ALUWB");
            end
            K_BRANCH: begin
                if (f3 == 3'b000 || f3 == 3'b001) begin
                    push(1'($urandom), z, op, f3,
                         ov(2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0,
                            (f3 == 3'b000) ? z : !z, 1'b0), "BRANCH");
                end else begin
                    m_ill = 1'b1;
                    gen_trap();
                    trapped = 1'b1;
                end
            end
            default: begin
                m_ill = 1'b1;
                gen_trap();
                trapped = 1'b1;
            end
        endcase
    endtask

    task automatic check(input logic [17:0] exp, input logic [63:0] tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %0s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_plan();
        step_t s;
        while (plan.size() > 0) begin
            s = plan.pop_front();
            @(posedge clk);
            #1;
            mem_ready = s.mr;
            zero      = s.z;
            opcode    = s.op;
            funct3    = s.f3;
            @(negedge clk);
            check(s.exp, s.tag);
        end
    endtask

    // Reset is asserted between clock edges to show it acts asynchronously;
    // exp_mw is the mem_write level expected just before it falls.
    task automatic do_reset(input logic exp_mw);
        @(posedge clk);
        #1;
        checks++;
        assert (mem_write === exp_mw) else begin
            errors++;
            $error("FAIL PRE_RESET_MEM_WRITE observed=%b expected=%b", mem_write, exp_mw);
        end
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        zero      = 1'($urandom);
        m_ill     = 1'b0;
        m_be      = 1'b0;
        #1;
        check(18'h0, "RST_ASYNC");
        @(negedge clk);
        check(18'h0, "RST_HOLD");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check(18'h0, "IDLE");
    endtask

    task automatic do_instr(input logic [6:0] op, input logic [2:0] f3,
                            input logic z, input int fdly, input int mdly);
        bit trapped;
        gen_instr(op, f3, z, fdly, mdly, trapped);
        run_plan();
        if (trapped) do_reset(1'b0);
    endtask

    initial begin
        bit   trapped;
        int   k;
        int   fd;
        int   md;
        logic [6:0] op;
        logic [2:0] f3;

        do_reset(1'b0);

        // Directed sequence
        do_instr(7'b0110011, 3'b000, 1'b0, 0, 0);           // add x3,x1,x2
        do_instr(7'b0100011, 3'b010, 1'b0, 0, 3);           // sw, ready after 3 waits
        do_instr(7'b1100011, 3'b000, 1'b1, 0, 0);           // beq taken
        do_instr(7'b1100011, 3'b000, 1'b0, 0, 0);           // beq not taken
        do_instr(7'b1100011, 3'b001, 1'b0, 0, 0);           // bne taken
        do_instr(7'b1100011, 3'b001, 1'b1, 1, 0);           // bne not taken
        do_instr(7'b0110111, 3'b010, 1'b0, 0, 0);           // lui x5,0x12345
        do_instr(7'b0000011, 3'b010, 1'b0, 2, 2);           // lw with waits
        do_instr(7'b0010011, 3'b000, 1'b0, 0, 0);           // addi
        do_instr(7'b0110011, 3'b111, 1'b0, WL - 1, 0);      // ready in limit cycle
        do_instr(7'b1101111, 3'b000, 1'b0, 0, 0);           // jal: unsupported
        do_instr(7'b0110011, 3'b000, 1'b0, WL, 0);          // fetch timeout
        do_instr(7'b1100011, 3'b100, 1'b0, 0, 0);           // blt: unsupported
        do_instr(7'b0000011, 3'b010, 1'b0, 0, WL);          // load timeout
        do_instr(7'b0100011, 3'b010, 1'b0, 0, WL - 1);      // store, limit-cycle ready

        // Reset in the middle of a store wait
        gen_instr(7'b0100011, 3'b010, 1'b0, 0, 3, trapped);
        void'(plan.pop_back());
        void'(plan.pop_back());
        run_plan();
        do_reset(1'b1);

        // Randomized instruction stream
        for (int n = 0; n < 40; n++) begin
            k  = $urandom_range(8, 0);
            fd = $urandom_range(WL - 1, 0);
            md = $urandom_range(WL, 0);
            f3 = 3'($urandom);
            case (k)
                0: op = 7'b0000011;
                1: op = 7'b0100011;
                2: op = 7'b0110011;
                3: op = 7'b0010011;
                4: begin op = 7'b1100011; f3 = {2'b00, 1'($urandom)}; end
                5: op = 7'b0110111;
                6: begin op = 7'b1100011; f3 = 3'($urandom_range(7, 2)); end
                7: op = bad_ops[$urandom_range(6, 0)];
                default: begin op = 7'b0110011; fd = WL + 1; end
            endcase
            do_instr(op, f3, 1'($urandom), fd, md);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
